// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the mpmc11 write-data path.
// The feeder FSM states and the default stall timeout live here.
package mpmc11_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FIN
    } mpmc11_wfeed_state_t;

    localparam int MPMC11_WFEED_TMO_DEF = 1023;
    localparam int MPMC11_STALL_W       = 16;

    // Beat counter width: clog2(beats), never below one bit.
    function automatic int mpmc11_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/mpmc11_beat_mux.sv
// Selects one beat of data and its byte mask out of a buffered write line.
// Purely combinational; the mask is the inverted byte-enable slice.
module mpmc11_beat_mux
    import mpmc11_pkg::*;
#(
    parameter int WID   = 256,
    parameter int BEATS = 2,
    parameter int CW    = mpmc11_cnt_w(BEATS)
) (
    input  logic [BEATS*WID-1:0]   line,
    input  logic [BEATS*WID/8-1:0] sel,
    input  logic [CW-1:0]          cnt,
    output logic [WID-1:0]         data,
    output logic [WID/8-1:0]       mask
);

    localparam int MW = WID / 8;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        data = '0;
        mask = '1;
        for (int b = 0; b < BEATS; b++) begin
            if (cnt == CW'(b)) begin
                data = line[b*WID +: WID];
                mask = ~sel[b*MW +: MW];
            end
        end
    end

endmodule

// File: rtl/mpmc11_wdata_feeder.sv
// Streams a captured write line onto the PHY app_wdf_* interface one beat at a time,
// honouring app_wdf_rdy backpressure and flagging stalls longer than TMO cycles.
module mpmc11_wdata_feeder
    import mpmc11_pkg::*;
#(
    parameter int WID   = 256,
    parameter int BEATS = 2,
    parameter int TMO   = MPMC11_WFEED_TMO_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [BEATS*WID-1:0]   dati,
    input  logic [BEATS*WID/8-1:0] seli,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic                   err_clr,
    output logic [WID-1:0]         app_wdf_data,
    output logic [WID/8-1:0]       app_wdf_mask,
    output logic                   app_wdf_wren,
    output logic                   app_wdf_end,
    input  logic                   app_wdf_rdy
);

    localparam int LW = BEATS * WID;
    localparam int SW = LW / 8;
    localparam int MW = WID / 8;
    localparam int CW = mpmc11_cnt_w(BEATS);
    localparam logic [CW-1:0]             LAST  = CW'(BEATS - 1);
    localparam logic [MPMC11_STALL_W-1:0] TMO_V = MPMC11_STALL_W'(TMO);

    mpmc11_wfeed_state_t state, state_n;

    logic [LW-1:0]             line, line_n;
    logic [SW-1:0]             sel, sel_n;
    logic [CW-1:0]             cnt, cnt_n;
    logic [MPMC11_STALL_W-1:0] stall, stall_n;
    logic                      err_n;
    logic [WID-1:0]            beat_data;
    logic [MW-1:0]             beat_mask;

    always_comb begin
        state_n = state;
        line_n  = line;
        sel_n   = sel;
        cnt_n   = cnt;
        stall_n = stall;
        err_n   = err;

        unique case (state)
            IDLE: begin
                if (start) begin
                    line_n  = dati;
                    sel_n   = seli;
                    cnt_n   = '0;
                    stall_n = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (app_wdf_rdy) begin
                    stall_n = '0;
                    if (cnt == LAST) state_n = FIN;
                    else             cnt_n   = cnt + 1'b1;
                end else if (stall != '1) begin
                    stall_n = stall + 1'b1;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // A timeout landing in the same cycle as err_clr must win.
        if (err_clr) err_n = 1'b0;
        if (state == SEND && !app_wdf_rdy && stall_n == TMO_V) err_n = 1'b1;
    end

    // Mux looks at next-cycle buffer and counter so the beat outputs can be registered.
    mpmc11_beat_mux #(
        .WID   (WID),
        .BEATS (BEATS),
        .CW    (CW)
    ) u_beat_mux (
        .line (line_n),
        .sel  (sel_n),
        .cnt  (cnt_n),
        .data (beat_data),
        .mask (beat_mask)
    );

    // NOTE: the line buffer is pure data, always loaded before it is read, so it has no reset.
    always_ff @(posedge clk) begin
        line <= line_n;
        sel  <= sel_n;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            stall        <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '1;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            stall        <= stall_n;
            err          <= err_n;
            busy         <= (state_n != IDLE);
            done         <= (state_n == FIN);
            app_wdf_wren <= (state_n == SEND);
            app_wdf_end  <= (state_n == SEND) && (cnt_n == LAST);
            app_wdf_data <= (state_n == SEND) ? beat_data : '0;
            app_wdf_mask <= (state_n == SEND) ? beat_mask : '1;
        end
    end

endmodule
